uart_tx_arbiter: RTL

- Shares the single UART transmit serializer between NUM_REQ byte-stream requesters, e.g. echo of received bytes, LED status reporter and debug dumper.
- Arbitration is round-robin at packet granularity: a granted requester keeps the serializer until it marks a last byte, hits the burst limit, or stalls past a timeout.
- Presents one registered valid/ready byte stream to the UART TX path, all in the 30 MHz PLL clock domain.

---
 rtl/uart_tx_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter sharing one UART TX byte stream between NUM_REQ sources.
// A grant lasts until a last byte, the burst limit, or a stall timeout; output is one register.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned DATA_W        = 8,
  parameter int unsigned MAX_BURST     = 16,
  parameter int unsigned STALL_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      tx_valid,
  output logic [DATA_W-1:0]         tx_data,
  input  logic                      tx_ready,
  output logic                      grant_valid,
  output logic [2:0]                grant_id,
  output logic                      busy
);

  localparam int unsigned IdxW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned StallW = $clog2(STALL_TIMEOUT);

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     gnt_q, gnt_d;
  logic [IdxW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [7:0]          burst_cnt_q, burst_cnt_d;
  logic [StallW-1:0]   stall_cnt_q, stall_cnt_d;
  logic                tx_valid_q, tx_valid_d;
  logic [DATA_W-1:0]   tx_data_q, tx_data_d;

  logic [DATA_W-1:0]   req_bytes [NUM_REQ];
  logic                found;
  logic [IdxW-1:0]     winner;
  logic [IdxW-1:0]     cand;
  logic                ready_g;
  logic                accept;
  logic                rel;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign req_bytes[gi] = req_data[gi*DATA_W +: DATA_W];
  end

  // Scan starts just past the last owner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = rr_ptr_q;
    cand   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = IdxW'((rr_ptr_q + i) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    stall_cnt_d = stall_cnt_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    req_ready   = '0;
    ready_g     = !tx_valid_q || tx_ready;
    accept      = 1'b0;
    rel         = 1'b0;

    case (state_q)
      StIdle: begin
        // A byte left over from the previous grant still drains while arbitrating.
        if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
        if (found) begin
          state_d     = StXfer;
          gnt_d       = winner;
          burst_cnt_d = '0;
          stall_cnt_d = '0;
        end
      end
      StXfer: begin
        req_ready[gnt_q] = ready_g;
        accept           = req_valid[gnt_q] && ready_g;
        if (accept) begin
          tx_data_d   = req_bytes[gnt_q];
          tx_valid_d  = 1'b1;
          burst_cnt_d = burst_cnt_q + 8'd1;
          stall_cnt_d = '0;
          if (req_last[gnt_q] || (burst_cnt_q == 8'(MAX_BURST - 1))) rel = 1'b1;
        end else begin
          if (tx_valid_q && tx_ready) tx_valid_d = 1'b0;
          if (stall_cnt_q == StallW'(STALL_TIMEOUT - 1)) begin
            rel = 1'b1;
          end else begin
            stall_cnt_d = stall_cnt_q + StallW'(1);
          end
        end
        if (rel) begin
          state_d  = StIdle;
          rr_ptr_d = gnt_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      gnt_q       <= '0;
      rr_ptr_q    <= IdxW'(NUM_REQ - 1);
      burst_cnt_q <= '0;
      stall_cnt_q <= '0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
    end
  end

  assign tx_valid    = tx_valid_q;
  assign tx_data     = tx_data_q;
  assign grant_valid = (state_q == StXfer);
  assign grant_id    = 3'(gnt_q);
  assign busy        = (state_q != StIdle) || tx_valid_q;

endmodule
